test_ad9739a: RTL and testbench

TEST_AD9739A -- requirements
Module: test_ad9739a

---
 rtl/ad9739a_pkg.sv | 39 +++
 rtl/ad9739a_spi_master.sv | 116 +++++++++++
 rtl/test_ad9739a.sv | 189 ++++++++++++++++++
 tb/tb_test_ad9739a.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ad9739a_pkg.sv
// Shared types and constants for the AD9739A test design: init FSM and SPI
// engine state encodings, the register write table and the lock register
// address.
package ad9739a_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_POLL,
        ST_RUN
    } state_t;

    typedef enum logic [2:0] {
        SPI_IDLE,
        SPI_LEAD,
        SPI_SHIFT,
        SPI_TRAIL,
        SPI_GAP
    } spi_state_t;

    localparam int         WR_COUNT  = 4;
    localparam logic [6:0] LOCK_ADDR = 7'h2A;

    localparam logic [6:0] WR_ADDR [WR_COUNT] = '{7'h00, 7'h00, 7'h10, 7'h26};
    localparam logic [7:0] WR_DATA [WR_COUNT] = '{8'h20, 8'h00, 8'h00, 8'h42};

    // SPI frame layout: {R/W (1 = read), addr[6:0], data[7:0]}, sent MSB first
    function automatic logic [15:0] spi_frame(input logic rnw,
                                              input logic [6:0] addr,
                                              input logic [7:0] data);
        return {rnw, addr, data};
    endfunction

    // Two's-complement sawtooth sample to offset-binary DAC code
    function automatic logic [13:0] dds_code(input logic [13:0] s);
        return {~s[13], s[12:0]};
    endfunction

endpackage

// File: rtl/ad9739a_spi_master.sv
// 16-bit mode-0 SPI frame engine. A one-cycle start pulse in idle launches a
// frame; busy stays high through the frame and the inter-frame gap, and
// rdata holds the bits captured on miso once busy falls.
module ad9739a_spi_master
    import ad9739a_pkg::*;
#(
    parameter int DIV = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] tx_data,
    output logic        busy,
    output logic [15:0] rdata,
    output logic        spi_csn,
    output logic        spi_clk,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    spi_state_t  state_reg, state_next;
    logic [7:0]  div_cnt_reg;
    logic [5:0]  edge_cnt_reg;
    logic [15:0] shift_reg;
    logic [15:0] rx_reg;
    logic [15:0] rdata_reg;
    logic        csn_reg;
    logic        sclk_reg;
    logic        tick;

    // One tick per spi_clk half-period
    assign tick = (div_cnt_reg == 8'(DIV - 1));

    assign busy     = (state_reg != SPI_IDLE);
    assign rdata    = rdata_reg;
    assign spi_csn  = csn_reg;
    assign spi_clk  = sclk_reg;
    assign spi_mosi = shift_reg[15];

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_reg <= SPI_IDLE;
        else     state_reg <= state_next;
    end

    // Frame sequencing: lead half-period, 32 clock edges, trail half-period, 2-half-period gap
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            SPI_IDLE:  if (start) state_next = SPI_LEAD;
            SPI_LEAD:  if (tick) state_next = SPI_SHIFT;
            SPI_SHIFT: if (tick && sclk_reg && edge_cnt_reg == 6'd31) state_next = SPI_TRAIL;
            SPI_TRAIL: if (tick) state_next = SPI_GAP;
            SPI_GAP:   if (tick && edge_cnt_reg[0]) state_next = SPI_IDLE;
            default:   state_next = SPI_IDLE;
        endcase
    end

    // Datapath: divider, edge counting, shift-out on falling edges, capture on rising edges
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_reg  <= '0;
            edge_cnt_reg <= '0;
            shift_reg    <= '0;
            rx_reg       <= '0;
            rdata_reg    <= '0;
            csn_reg      <= 1'b1;
            sclk_reg     <= 1'b0;
        end else begin
            if (state_reg == SPI_IDLE || tick) div_cnt_reg <= '0;
            else                               div_cnt_reg <= div_cnt_reg + 8'd1;

            case (state_reg)
                SPI_IDLE: begin
                    if (start) begin
                        shift_reg    <= tx_data;
                        csn_reg      <= 1'b0;
                        edge_cnt_reg <= '0;
                    end
                end
                SPI_LEAD: begin
                    if (tick) begin
                        sclk_reg     <= 1'b1;
                        rx_reg       <= {rx_reg[14:0], spi_miso};
                        edge_cnt_reg <= 6'd1;
                    end
                end
                SPI_SHIFT: begin
                    if (tick) begin
                        edge_cnt_reg <= edge_cnt_reg + 6'd1;
                        if (sclk_reg) begin
                            // Falling edge: present the next bit; zeros fill in behind
                            sclk_reg  <= 1'b0;
                            shift_reg <= {shift_reg[14:0], 1'b0};
                        end else begin
                            sclk_reg <= 1'b1;
                            rx_reg   <= {rx_reg[14:0], spi_miso};
                        end
                    end
                end
                SPI_TRAIL: begin
                    if (tick) begin
                        csn_reg      <= 1'b1;
                        rdata_reg    <= rx_reg;
                        edge_cnt_reg <= '0;
                    end
                end
                SPI_GAP: begin
                    if (tick) edge_cnt_reg <= edge_cnt_reg + 6'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/test_ad9739a.sv
// AD9739A bring-up design: after a short idle it writes the register table
// over SPI, optionally polls the lock register (define AD9739A_LOCK_POLL_EN),
// then runs a two-phase DDS sawtooth onto the A/B data ports.
module test_ad9739a
    import ad9739a_pkg::*;
#(
    parameter int          SPI_DIV = 8,
    parameter logic [31:0] FTW     = 32'h0100_0000
) (
    input  logic        CLK_P,
    input  logic        rst,
    output logic        dac_clk_out_p,
    output logic        dac_clk_out_n,
    output logic [13:0] dac_data_out_a_p,
    output logic [13:0] dac_data_out_a_n,
    output logic [13:0] dac_data_out_b_p,
    output logic [13:0] dac_data_out_b_n,
    output logic [1:0]  spi_csn,
    output logic        spi_clk,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic [3:0]  gpio_led
);

    localparam logic [1:0] LAST_IDX = 2'(WR_COUNT - 1);

    state_t      state_reg, state_next;
    logic [3:0]  idle_cnt_reg, idle_cnt_next;
    logic [1:0]  idx_reg, idx_next;
    logic        sent_reg, sent_next;
    logic        spi_start;
    logic [15:0] spi_tx;
    logic        spi_busy;
    logic        spi_csn_dac;
    logic        lock;
`ifdef AD9739A_LOCK_POLL_EN
    logic [5:0]  poll_cnt_reg, poll_cnt_next;
    logic        lock_reg, lock_next;
    logic [15:0] spi_rdata;
`endif

    logic [31:0] acc_reg;
    logic [13:0] data_a_reg, data_b_reg;
    logic [13:0] sample_a, sample_b;
    logic        dclk_reg;
    logic [23:0] hb_cnt_reg;

    ad9739a_spi_master #(
        .DIV(SPI_DIV)
    ) u_spi (
        .clk      (CLK_P),
        .rst      (rst),
        .start    (spi_start),
        .tx_data  (spi_tx),
        .busy     (spi_busy),
`ifdef AD9739A_LOCK_POLL_EN
        .rdata    (spi_rdata),
`else
        .rdata    (),
`endif
        .spi_csn  (spi_csn_dac),
        .spi_clk  (spi_clk),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso)
    );

`ifdef AD9739A_LOCK_POLL_EN
    assign lock = lock_reg;
`else
    assign lock = 1'b0;
`endif

    // Init FSM and sequencing registers
    always_ff @(posedge CLK_P) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            idle_cnt_reg <= '0;
            idx_reg      <= '0;
            sent_reg     <= 1'b0;
`ifdef AD9739A_LOCK_POLL_EN
            poll_cnt_reg <= '0;
            lock_reg     <= 1'b0;
`endif
        end else begin
            state_reg    <= state_next;
            idle_cnt_reg <= idle_cnt_next;
            idx_reg      <= idx_next;
            sent_reg     <= sent_next;
`ifdef AD9739A_LOCK_POLL_EN
            poll_cnt_reg <= poll_cnt_next;
            lock_reg     <= lock_next;
`endif
        end
    end

    // Next-state logic: one start pulse per frame, then wait for the engine to go idle
    always_comb begin
        state_next    = state_reg;
        idle_cnt_next = idle_cnt_reg;
        idx_next      = idx_reg;
        sent_next     = sent_reg;
        spi_start     = 1'b0;
        spi_tx        = spi_frame(1'b0, WR_ADDR[idx_reg], WR_DATA[idx_reg]);
`ifdef AD9739A_LOCK_POLL_EN
        poll_cnt_next = poll_cnt_reg;
        lock_next     = lock_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                idle_cnt_next = idle_cnt_reg + 4'd1;
                if (idle_cnt_reg == 4'd15) state_next = ST_WRITE;
            end
            ST_WRITE: begin
                if (!sent_reg) begin
                    spi_start = 1'b1;
                    sent_next = 1'b1;
                end else if (!spi_busy) begin
                    sent_next = 1'b0;
                    if (idx_reg == LAST_IDX) begin
`ifdef AD9739A_LOCK_POLL_EN
                        state_next = ST_POLL;
`else
                        state_next = ST_RUN;
`endif
                    end else begin
                        idx_next = idx_reg + 2'd1;
                    end
                end
            end
`ifdef AD9739A_LOCK_POLL_EN
            ST_POLL: begin
                spi_tx = spi_frame(1'b1, LOCK_ADDR, 8'h00);
                if (!sent_reg) begin
                    spi_start = 1'b1;
                    sent_next = 1'b1;
                end else if (!spi_busy) begin
                    sent_next     = 1'b0;
                    poll_cnt_next = poll_cnt_reg + 6'd1;
                    if (spi_rdata[0]) begin
                        lock_next  = 1'b1;
                        state_next = ST_RUN;
                    end else if (poll_cnt_reg == 6'd63) begin
                        state_next = ST_RUN;
                    end
                end
            end
`endif
            ST_RUN: ;
            default: state_next = ST_IDLE;
        endcase
    end

    assign sample_a = acc_reg[31:18];
    assign sample_b = 14'((acc_reg + FTW) >> 18);

    // DDS: two phases per cycle, held at midscale with a cleared accumulator until RUN
    always_ff @(posedge CLK_P) begin
        if (rst || state_reg != ST_RUN) begin
            acc_reg    <= '0;
            data_a_reg <= 14'h2000;
            data_b_reg <= 14'h2000;
        end else begin
            acc_reg    <= acc_reg + (FTW << 1);
            data_a_reg <= dds_code(sample_a);
            data_b_reg <= dds_code(sample_b);
        end
    end

    // Forwarded data clock and heartbeat counter
    always_ff @(posedge CLK_P) begin
        if (rst) begin
            dclk_reg   <= 1'b0;
            hb_cnt_reg <= '0;
        end else begin
            dclk_reg   <= ~dclk_reg;
            hb_cnt_reg <= hb_cnt_reg + 24'd1;
        end
    end

    assign dac_clk_out_p    = dclk_reg;
    assign dac_clk_out_n    = ~dclk_reg;
    assign dac_data_out_a_p = data_a_reg;
    assign dac_data_out_a_n = ~data_a_reg;
    assign dac_data_out_b_p = data_b_reg;
    assign dac_data_out_b_n = ~data_b_reg;
    assign spi_csn          = {1'b1, spi_csn_dac};
    assign gpio_led         = {hb_cnt_reg[23], lock, ~spi_csn_dac, state_reg == ST_RUN};

endmodule

// File: tb/tb_test_ad9739a.sv
// Scoreboard bench for test_ad9739a: expected SPI frames and DDS samples are
// queued by the stimulus; a negedge monitor decodes the DUT pins and checks.
module tb_test_ad9739a;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        miso = 1'b0;
    logic        dac_clk_out_p, dac_clk_out_n;
    logic [13:0] dac_data_out_a_p, dac_data_out_a_n;
    logic [13:0] dac_data_out_b_p, dac_data_out_b_n;
    logic [1:0]  spi_csn;
    logic        spi_clk, spi_mosi;
    logic [3:0]  gpio_led;

    always #5 clk = ~clk;

    test_ad9739a #(
        .SPI_DIV(8),
        .FTW    (32'h0100_0000)
    ) dut (
        .CLK_P            (clk),
        .rst              (rst),
        .dac_clk_out_p    (dac_clk_out_p),
        .dac_clk_out_n    (dac_clk_out_n),
        .dac_data_out_a_p (dac_data_out_a_p),
        .dac_data_out_a_n (dac_data_out_a_n),
        .dac_data_out_b_p (dac_data_out_b_p),
        .dac_data_out_b_n (dac_data_out_b_n),
        .spi_csn          (spi_csn),
        .spi_clk          (spi_clk),
        .spi_mosi         (spi_mosi),
        .spi_miso         (miso),
        .gpio_led         (gpio_led)
    );

    typedef struct {
        int          k;
        logic [13:0] a;
        logic [13:0] b;
    } dds_t;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] spi_q[$];
    dds_t        dds_q[$];

    // Monitor state
    int          cyc = 0, since_rst = 0, t_fall = 0, t_rise = 0, t_lastfall = 0, t_csnrise = 0;
    int          bits = 0, run_n = 0, k = 0, frames_done = 0, rd_frames = 0;
    int          lock_after = -1;
    logic        in_frame = 1'b0, first_pending = 1'b1, exp_lock = 1'b0;
    logic        prev_csn0 = 1'b1, prev_sclk = 1'b0, prev_dclk = 1'b0, rst_seen = 1'b1;
    logic [15:0] cap, expf;
    logic [13:0] sa, sb, prev_sa, d;
    logic [28:0] xr;
    dds_t        e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Reset as the DUT saw it at the last rising edge
    always @(posedge clk) rst_seen <= rst;

    // Pin-level monitor
    always @(negedge clk) begin
        cyc = cyc + 1;
        xr = {dac_clk_out_p ^ dac_clk_out_n, dac_data_out_a_p ^ dac_data_out_a_n,
              dac_data_out_b_p ^ dac_data_out_b_n};
        chk("complement", {3'b0, xr}, 32'h1FFF_FFFF);
        if (rst_seen) begin
            chk("reset_ctrl", {23'b0, spi_csn, spi_clk, spi_mosi, dac_clk_out_p, gpio_led}, 32'h0000_0180);
            chk("reset_data", {4'b0, dac_data_out_a_p, dac_data_out_b_p}, {4'b0, 14'h2000, 14'h2000});
            in_frame = 1'b0; bits = 0; since_rst = 0; first_pending = 1'b1;
            run_n = 0; frames_done = 0; rd_frames = 0;
        end else begin
            since_rst++;
            chk("dclk_toggle", {31'b0, dac_clk_out_p}, {31'b0, ~prev_dclk});
            chk("csn1_led1", {30'b0, spi_csn[1], gpio_led[1]}, {30'b0, 1'b1, ~spi_csn[0]});
            if (prev_csn0 && !spi_csn[0]) begin
                if (first_pending) chk("idle_len", since_rst, 17);
                else               chk("csn_gap", {31'b0, (cyc - t_csnrise) >= 16}, 32'd1);
                first_pending = 1'b0; in_frame = 1'b1; bits = 0; cap = '0; t_fall = cyc;
            end
            if (in_frame && !prev_sclk && spi_clk) begin
                cap = {cap[14:0], spi_mosi};
                bits++;
                if (bits == 1) chk("lead", cyc - t_fall, 8);
                else           chk("sclk_period", cyc - t_rise, 16);
                t_rise = cyc;
            end
            if (prev_sclk && !spi_clk) t_lastfall = cyc;
            if (in_frame && !prev_csn0 && spi_csn[0]) begin
                in_frame = 1'b0; t_csnrise = cyc;
                chk("bit_count", bits, 16);
                chk("trail", cyc - t_lastfall, 8);
                if (spi_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL frame_unexpected: got %h required no frame", cap);
                end else begin
                    expf = spi_q.pop_front();
                    $display("frame %0d: mosi %h expected %h", frames_done, cap, expf);
                    chk("frame", {16'b0, cap}, {16'b0, expf});
                end
                frames_done++;
                if (cap[15]) rd_frames++;
            end
            if (!gpio_led[0] || run_n == 0)
                chk("midscale", {4'b0, dac_data_out_a_p, dac_data_out_b_p}, {4'b0, 14'h2000, 14'h2000});
            if (gpio_led[0]) begin
                chk("run_status", {28'b0, spi_csn[0], gpio_led[2:0]}, {28'b0, 1'b1, exp_lock, 2'b01});
                if (run_n > 0) begin
                    k = run_n - 1;
                    sa = dac_data_out_a_p ^ 14'h2000;
                    sb = dac_data_out_b_p ^ 14'h2000;
                    if (k > 0) begin
                        d = sa - prev_sa;
                        chk("a_step", {18'b0, d}, 32'h80);
                    end
                    d = sb - sa;
                    chk("b_offset", {18'b0, d}, 32'h40);
                    if (dds_q.size() > 0 && dds_q[0].k == k) begin
                        e = dds_q.pop_front();
                        $display("sample %0d: a %h b %h expected %h %h", k,
                                 dac_data_out_a_p, dac_data_out_b_p, e.a, e.b);
                        chk("dds_a", {18'b0, dac_data_out_a_p}, {18'b0, e.a});
                        chk("dds_b", {18'b0, dac_data_out_b_p}, {18'b0, e.b});
                    end
                    prev_sa = sa;
                end
                run_n++;
            end
        end
        prev_csn0 = spi_csn[0];
        prev_sclk = spi_clk;
        prev_dclk = dac_clk_out_p;
    end

    // Lock-register responder: drive miso high for the last bit of the chosen read
    initial begin
        forever begin
            @(negedge clk);
            #1;
            miso = (lock_after >= 0) && (rd_frames >= lock_after) && in_frame && (bits == 15);
        end
    end

    // Hand-computed samples for FTW = 0x0100_0000 (A/B codes by sample index)
    task automatic push_table();
        dds_q.push_back('{0,   14'h2000, 14'h2040});
        dds_q.push_back('{1,   14'h2080, 14'h20C0});
        dds_q.push_back('{63,  14'h3F80, 14'h3FC0});
        dds_q.push_back('{64,  14'h0000, 14'h0040});
        dds_q.push_back('{127, 14'h1F80, 14'h1FC0});
        dds_q.push_back('{128, 14'h2000, 14'h2040});
    endtask

    task automatic push_writes();
        spi_q.push_back(16'h0020);
        spi_q.push_back(16'h0000);
        spi_q.push_back(16'h1000);
        spi_q.push_back(16'h2642);
    endtask

    task automatic wait_run(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (gpio_led[0]) break;
        end
        chk("run_reached", {31'b0, gpio_led[0]}, 32'd1);
    endtask

    task automatic run_and_check(input int exp_frames);
        wait_run(30000);
        repeat (140) @(posedge clk);
        chk("spi_queue_empty", spi_q.size(), 0);
        chk("dds_queue_empty", dds_q.size(), 0);
        chk("frame_total", frames_done, exp_frames);
    endtask

    initial begin
        // Run 1: first frame completes, reset lands inside the second frame
        rst = 1'b1;
        repeat (4) @(posedge clk);
        spi_q.push_back(16'h0020);
        #1 rst = 1'b0;
        begin
            int i;
            for (i = 0; i < 5000; i++) begin
                @(posedge clk);
                if (frames_done == 1 && !spi_csn[0]) break;
            end
            chk("second_frame_started", {31'b0, spi_csn[0]}, 32'd0);
        end
        repeat (40) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_csn", {30'b0, spi_csn}, 32'd3);
        chk("abort_sclk", {31'b0, spi_clk}, 32'd0);
        repeat (3) @(posedge clk);
        chk("abort_queue", spi_q.size(), 0);

        // Run 2: full sequence from frame 1, then DDS
        push_writes();
`ifdef AD9739A_LOCK_POLL_EN
        for (int j = 0; j < 4; j++) spi_q.push_back(16'hAA00);
        lock_after = 3;
        exp_lock   = 1'b1;
`else
        exp_lock   = 1'b0;
`endif
        push_table();
        @(posedge clk);
        #1 rst = 1'b0;
`ifdef AD9739A_LOCK_POLL_EN
        run_and_check(8);

        // Run 3: lock never reported, 64 reads then RUN without lock
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        lock_after = -1;
        exp_lock   = 1'b0;
        push_writes();
        for (int j = 0; j < 64; j++) spi_q.push_back(16'hAA00);
        push_table();
        @(posedge clk);
        #1 rst = 1'b0;
        run_and_check(68);
`else
        run_and_check(4);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
